// File: rtl/verilog_comment_strip_if.sv
// Valid/ready byte streams between the raw source feeder, the comment
// stripper and the downstream tokenizer, plus the sticky error flag.
interface verilog_comment_strip_if #(
    parameter int LINE_W = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [LINE_W-1:0] out_line;
    logic              err_unterminated;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_line, err_unterminated
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_line, err_unterminated
    );
endinterface

// File: rtl/verilog_comment_strip.sv
// Removes // and /* */ comments from a Verilog byte stream, keeping newlines
// so every surviving byte can be tagged with its exact source line.
module verilog_comment_strip #(
    parameter int LINE_W = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    verilog_comment_strip_if.slave bus
);
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_QUOTE = 8'h22;
    localparam logic [7:0] CH_BSL   = 8'h5C;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;

    typedef enum logic [3:0] {
        CODE    = 4'd0,
        SLASH   = 4'd1,
        LINE    = 4'd2,
        BLOCK   = 4'd3,
        BSTAR   = 4'd4,
        STR     = 4'd5,
        STR_ESC = 4'd6,
        ESCID   = 4'd7,
        PEND    = 4'd8
    } state_t;

    state_t            state_q, state_d, cur_state_s;
    logic [7:0]        hold_q, hold_d;
    logic              hold_last_q, hold_last_d;
    logic              out_valid_q, out_last_q;
    logic [7:0]        out_data_q;
    logic [LINE_W-1:0] out_line_q, line_q;
    logic              err_q, first_q;
    logic              pend_s, slot_free_s, in_ready_s, accept_s, go_s;
    logic [7:0]        cur_byte_s, emit_data_s;
    logic              cur_last_s, is_nl_s;
    logic              emit_s, emit_last_s, err_set_s, defer_s;

    // In PEND the held byte is replayed through the CODE rules without taking input.
    assign pend_s      = (state_q == PEND);
    assign slot_free_s = !out_valid_q || bus.out_ready;
    assign in_ready_s  = reset_n && slot_free_s && !pend_s;
    assign accept_s    = bus.in_valid && in_ready_s;
    assign go_s        = pend_s ? slot_free_s : accept_s;
    assign cur_state_s = pend_s ? CODE : state_q;
    assign cur_byte_s  = pend_s ? hold_q : bus.in_data;
    assign cur_last_s  = pend_s ? hold_last_q : bus.in_last;
    assign is_nl_s     = (cur_byte_s == CH_NL);

    assign bus.in_ready         = in_ready_s;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;
    assign bus.out_last         = out_last_q;
    assign bus.out_line         = out_line_q;
    assign bus.err_unterminated = err_q;

    // Next-state and emit decision for the byte being processed this cycle.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        emit_s      = 1'b0;
        emit_data_s = cur_byte_s;
        emit_last_s = 1'b0;
        err_set_s   = 1'b0;
        defer_s     = 1'b0;
        if (go_s) begin
            case (cur_state_s)
                CODE: begin
                    emit_s = 1'b1;
                    if (cur_byte_s == CH_SLASH) begin
                        emit_s  = cur_last_s;
                        state_d = SLASH;
                    end else if (cur_byte_s == CH_QUOTE) begin
                        state_d = STR;
                    end else if (cur_byte_s == CH_BSL) begin
                        state_d = ESCID;
                    end else begin
                        state_d = CODE;
                    end
                end
                SLASH: begin
                    if ((cur_byte_s == CH_SLASH) || (cur_byte_s == CH_STAR)) begin
                        state_d     = (cur_byte_s == CH_SLASH) ? LINE : BLOCK;
                        emit_data_s = CH_SP;
                        emit_s      = cur_last_s;
                        err_set_s   = cur_last_s;
                    end else begin
                        emit_s      = 1'b1;
                        emit_data_s = CH_SLASH;
                        hold_d      = cur_byte_s;
                        hold_last_d = cur_last_s;
                        state_d     = PEND;
                        defer_s     = 1'b1;
                    end
                end
                LINE: begin
                    emit_data_s = CH_NL;
                    emit_s      = is_nl_s || cur_last_s;
                    if (is_nl_s) begin
                        state_d = CODE;
                    end else begin
                        state_d = LINE;
                    end
                end
                BLOCK: begin
                    emit_data_s = is_nl_s ? CH_NL : CH_SP;
                    emit_s      = is_nl_s || cur_last_s;
                    err_set_s   = cur_last_s;
                    if (cur_byte_s == CH_STAR) begin
                        state_d = BSTAR;
                    end else begin
                        state_d = BLOCK;
                    end
                end
                BSTAR: begin
                    emit_data_s = is_nl_s ? CH_NL : CH_SP;
                    emit_s      = is_nl_s || cur_last_s;
                    err_set_s   = cur_last_s && (cur_byte_s != CH_SLASH);
                    if (cur_byte_s == CH_SLASH) begin
                        emit_s  = 1'b1;
                        state_d = CODE;
                    end else if (cur_byte_s == CH_STAR) begin
                        state_d = BSTAR;
                    end else begin
                        state_d = BLOCK;
                    end
                end
                STR: begin
                    emit_s    = 1'b1;
                    err_set_s = cur_last_s && (cur_byte_s != CH_QUOTE);
                    if (cur_byte_s == CH_BSL) begin
                        state_d = STR_ESC;
                    end else if (cur_byte_s == CH_QUOTE) begin
                        state_d = CODE;
                    end else begin
                        state_d = STR;
                    end
                end
                STR_ESC: begin
                    emit_s    = 1'b1;
                    err_set_s = cur_last_s;
                    state_d   = STR;
                end
                ESCID: begin
                    emit_s = 1'b1;
                    if ((cur_byte_s == CH_SP) || (cur_byte_s == CH_TAB) || is_nl_s) begin
                        state_d = CODE;
                    end else begin
                        state_d = ESCID;
                    end
                end
                default: begin
                    state_d = CODE;
                end
            endcase
            // Every file end produces exactly one beat, and the scanner restarts in CODE.
            if (cur_last_s && !defer_s) begin
                state_d     = CODE;
                emit_s      = 1'b1;
                emit_last_s = 1'b1;
            end else begin
                emit_last_s = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, hold, output stage, line counter and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CODE;
            hold_q      <= 8'h00;
            hold_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_line_q  <= LINE_W'(1);
            line_q      <= LINE_W'(1);
            err_q       <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            if (go_s && emit_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= emit_data_s;
                out_last_q  <= emit_last_s;
                out_line_q  <= line_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A held byte counts its newline/last only when it is finally replayed.
            if (go_s && !defer_s) begin
                if (cur_last_s) begin
                    line_q <= LINE_W'(1);
                end else if (is_nl_s && (line_q != {LINE_W{1'b1}})) begin
                    line_q <= line_q + LINE_W'(1);
                end
            end
            if (go_s && err_set_s) begin
                err_q <= 1'b1;
            end else if (accept_s && first_q) begin
                err_q <= 1'b0;
            end
            if (go_s && !defer_s && cur_last_s) begin
                first_q <= 1'b1;
            end else if (accept_s) begin
                first_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_verilog_comment_strip.sv
// Directed streams with hand-derived expected beats queued to a scoreboard;
// an independent monitor pops and compares on every output handshake.
module tb_verilog_comment_strip;
    localparam int LINE_W = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    verilog_comment_strip_if #(.LINE_W(LINE_W)) bus ();
    verilog_comment_strip #(.LINE_W(LINE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         ln;
    } beat_t;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    stall_cnt   = 0;
    bit    bp_en       = 1'b0;

    function automatic string xl(input string s);
        string r;
        r = s;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                8'h40:   r[i] = 8'h0A;
                8'h5E:   r[i] = 8'h22;
                8'h7E:   r[i] = 8'h5C;
                default: r[i] = s[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queue every character of s as an expected beat on line ln; last flags the final one.
    task automatic exps(input string s, input int ln, input bit last);
        beat_t b;
        for (int i = 0; i < s.len(); i++) begin
            b.d  = s[i];
            b.l  = last && (i == s.len() - 1);
            b.ln = ln;
            sb.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit got;
        int guard;
        got   = 1'b0;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!got && guard < 200) begin
            #1;
            got = bus.in_ready;
            @(posedge clk);
            if (!got) begin
                @(negedge clk);
            end
            guard++;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready timeout: byte %h never accepted", d);
        end
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last && (i == s.len() - 1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d beats still missing, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Downstream backpressure, randomised only when bp_en is set.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compares each output handshake against the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && bus.in_valid && !bus.in_ready) stall_cnt++;
            if (reset_n && bus.out_valid && bus.out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat: unexpected data=%h last=%0d line=%0d, expected none",
                             bus.out_data, bus.out_last, bus.out_line);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_data !== e.d || bus.out_last !== e.l || bus.out_line !== LINE_W'(e.ln)) begin
                        miscompares++;
                        $display("FAIL beat: got data=%h last=%0d line=%0d, expected data=%h last=%0d line=%0d",
                                 bus.out_data, bus.out_last, bus.out_line, e.d, e.l, e.ln);
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #12;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_data", int'(bus.out_data), 0);
        check("reset out_last", int'(bus.out_last), 0);
        check("reset out_line", int'(bus.out_line), 1);
        check("reset err", int'(bus.err_unterminated), 0);
        check("reset in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;

        exps(xl("a@"), 1, 1'b0); exps("b", 2, 1'b1);
        send_str(xl("a//x@b"), 1'b1); drain();

        exps(xl("x@"), 1, 1'b0); exps(" y", 2, 1'b1);
        send_str(xl("x/*1@2*/y"), 1'b1); drain();
        check("block err", int'(bus.err_unterminated), 0);

        stall_cnt = 0;
        exps(xl("^a//~^b^/c;"), 1, 1'b1);
        send_str(xl("^a//~^b^/c;"), 1'b1); drain();
        check("pend stall cycles", stall_cnt, 1);

        exps(xl("~a//b c@"), 1, 1'b1);
        send_str(xl("~a//b c//z@"), 1'b1); drain();

        exps(xl("@"), 1, 1'b0); exps(" ", 2, 1'b1);
        send_str(xl("/*@ab"), 1'b1); drain();
        check("unterminated block err", int'(bus.err_unterminated), 1);

        exps(" ", 1, 1'b1);
        send_str("/**/", 1'b1); drain();
        check("closed at last err", int'(bus.err_unterminated), 0);

        exps(xl("^ab"), 1, 1'b1);
        send_str(xl("^ab"), 1'b1); drain();
        check("unterminated string err", int'(bus.err_unterminated), 1);

        exps("m/", 1, 1'b1);
        send_str("m/", 1'b1); drain();
        check("slash last err", int'(bus.err_unterminated), 0);

        exps(xl("@"), 1, 1'b1);
        send_str("//q", 1'b1); drain();
        check("line comment at end err", int'(bus.err_unterminated), 0);

        exps(xl("/@"), 1, 1'b0); exps("z", 2, 1'b1);
        send_str(xl("/@z"), 1'b1); drain();

        bp_en = 1'b1;
        exps(xl("a@"), 1, 1'b0); exps("b", 2, 1'b1);
        send_str(xl("a//x@b"), 1'b1);
        exps(xl("x@"), 1, 1'b0); exps(" y", 2, 1'b1);
        send_str(xl("x/*1@2*/y"), 1'b1);
        exps(xl("^a//~^b^/c;"), 1, 1'b1);
        send_str(xl("^a//~^b^/c;"), 1'b1);
        exps("a/b", 1, 1'b1);
        send_str("a/b", 1'b1);
        exps(xl("p=q/r;@"), 1, 1'b0); exps(xl(" s^//^@"), 2, 1'b1);
        send_str(xl("p=q/r;//c@/*x*/s^//^@"), 1'b1);
        drain();
        bp_en = 1'b0;
        repeat (2) @(negedge clk);

        exps(xl("@"), 1, 1'b0); exps("q", 2, 1'b0);
        send_str(xl("@q/*ab"), 1'b0); drain();
        check("pre-reset out_line", int'(bus.out_line), 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid reset out_valid", int'(bus.out_valid), 0);
        check("mid reset out_data", int'(bus.out_data), 0);
        check("mid reset out_line", int'(bus.out_line), 1);
        check("mid reset out_last", int'(bus.out_last), 0);
        check("mid reset err", int'(bus.err_unterminated), 0);
        check("mid reset in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exps("k", 1, 1'b1);
        send_str("k", 1'b1); drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
